// File: rtl/fb_tile_writer.sv
// Frame-buffer writer: clears the RAM to the background colour, then keeps a
// single highlighted cursor tile that moves with two debounced push buttons.
module fb_tile_writer #(
  parameter int              AW              = 6,
  parameter int              DW              = 6,
  parameter int              NUM_TILES       = 16,
  parameter logic [DW-1:0]   BG_COLOR        = 6'b000011,
  parameter logic [DW-1:0]   CURSOR_COLOR    = 6'b110000,
  parameter int              DEBOUNCE_CYCLES = 250000
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          btn_right,
  input  logic          btn_left,
  output logic [AW-1:0] mem_px_addr,
  output logic [DW-1:0] mem_px_data,
  output logic          px_wr,
  output logic          busy,
  output logic [3:0]    cursor
);

  localparam int            CW        = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST  = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [AW:0]   CLR_END   = {1'b1, {AW{1'b0}}};
  localparam logic [3:0]    LAST_TILE = 4'(NUM_TILES - 1);

  typedef enum logic [1:0] {S_CLEAR, S_IDLE, S_ERASE, S_DRAW} state_t;

  // Button conditioning; bit 0 = right, bit 1 = left
  logic [1:0]    raw;
  logic [1:0]    sync1_q, sync2_q, db_q, press_q;
  logic [CW-1:0] cnt_q [2];

  assign raw = {btn_left, btn_right};

  always_ff @(posedge clk) begin
    if (!rst) begin
      sync1_q <= '0;
      sync2_q <= '0;
      db_q    <= '0;
      press_q <= '0;
      for (int unsigned b = 0; b < 2; b++) cnt_q[b] <= '0;
    end else begin
      sync1_q <= raw;
      sync2_q <= sync1_q;
      press_q <= '0;
      for (int unsigned b = 0; b < 2; b++) begin
        if (sync2_q[b] == db_q[b]) begin
          cnt_q[b] <= '0;
        end else if (cnt_q[b] == CNT_LAST) begin
          cnt_q[b]   <= '0;
          db_q[b]    <= sync2_q[b];
          press_q[b] <= sync2_q[b];
        end else begin
          cnt_q[b] <= cnt_q[b] + CW'(1);
        end
      end
    end
  end

  state_t        state_q, state_d;
  logic [AW:0]   clr_addr_q, clr_addr_d;
  logic [3:0]    cursor_q, cursor_d, next_q, next_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [DW-1:0] data_q, data_d;
  logic          wr_q, wr_d, busy_q, busy_d;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= S_CLEAR;
      clr_addr_q <= '0;
      cursor_q   <= '0;
      next_q     <= '0;
      addr_q     <= '0;
      data_q     <= '0;
      wr_q       <= 1'b0;
      busy_q     <= 1'b1;
    end else begin
      state_q    <= state_d;
      clr_addr_q <= clr_addr_d;
      cursor_q   <= cursor_d;
      next_q     <= next_d;
      addr_q     <= addr_d;
      data_q     <= data_d;
      wr_q       <= wr_d;
      busy_q     <= busy_d;
    end
  end

  // Outputs are registered, so each state loads the write that becomes
  // visible on the following cycle; state_q names the write being shown.
  always_comb begin
    state_d    = state_q;
    clr_addr_d = clr_addr_q;
    cursor_d   = cursor_q;
    next_d     = next_q;
    addr_d     = addr_q;
    data_d     = data_q;
    wr_d       = 1'b0;
    busy_d     = 1'b1;
    unique case (state_q)
      S_CLEAR: begin
        wr_d = 1'b1;
        if (clr_addr_q == CLR_END) begin
          addr_d  = AW'(cursor_q);
          data_d  = CURSOR_COLOR;
          state_d = S_DRAW;
        end else begin
          addr_d     = clr_addr_q[AW-1:0];
          data_d     = BG_COLOR;
          clr_addr_d = clr_addr_q + 1'b1;
        end
      end
      S_IDLE: begin
        busy_d = 1'b0;
        if (press_q[0] ^ press_q[1]) begin
          if (press_q[0]) next_d = (cursor_q == LAST_TILE) ? 4'd0 : cursor_q + 4'd1;
          else            next_d = (cursor_q == 4'd0) ? LAST_TILE : cursor_q - 4'd1;
          wr_d    = 1'b1;
          busy_d  = 1'b1;
          addr_d  = AW'(cursor_q);
          data_d  = BG_COLOR;
          state_d = S_ERASE;
        end
      end
      S_ERASE: begin
        cursor_d = next_q;
        wr_d     = 1'b1;
        addr_d   = AW'(next_q);
        data_d   = CURSOR_COLOR;
        state_d  = S_DRAW;
      end
      S_DRAW: begin
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
      default: state_d = S_CLEAR;
    endcase
  end

  assign mem_px_addr = addr_q;
  assign mem_px_data = data_q;
  assign px_wr       = wr_q;
  assign busy        = busy_q;
  assign cursor      = cursor_q;

endmodule

// File: tb/tb_fb_tile_writer.sv
// Directed bench for fb_tile_writer: expected RAM writes are queued as stimulus
// is applied and matched against every px_wr cycle observed on the write port.
module tb_fb_tile_writer;

  localparam int         AW  = 6;
  localparam int         DW  = 6;
  localparam int         NT  = 16;
  localparam int         DC  = 4;
  localparam logic [5:0] BG  = 6'b000011;
  localparam logic [5:0] CUR = 6'b110000;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          btn_right = 1'b0;
  logic          btn_left  = 1'b0;
  logic [AW-1:0] mem_px_addr;
  logic [DW-1:0] mem_px_data;
  logic          px_wr, busy;
  logic [3:0]    cursor;

  always #5 clk = ~clk;

  fb_tile_writer #(
    .AW(AW), .DW(DW), .NUM_TILES(NT), .BG_COLOR(BG),
    .CURSOR_COLOR(CUR), .DEBOUNCE_CYCLES(DC)
  ) dut (
    .clk(clk), .rst(rst), .btn_right(btn_right), .btn_left(btn_left),
    .mem_px_addr(mem_px_addr), .mem_px_data(mem_px_data),
    .px_wr(px_wr), .busy(busy), .cursor(cursor)
  );

  int          vectors = 0;
  int          miscompares = 0;
  logic [11:0] exp_q[$];
  bit          mon_en = 1'b0;
  logic [5:0]  ram [64];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push_wr(input int a, input logic [5:0] d);
    exp_q.push_back({6'(a), d});
  endtask

  task automatic push_clear();
    for (int i = 0; i < 64; i++) push_wr(i, BG);
    push_wr(0, CUR);
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_addr"},   32'(mem_px_addr), 32'd0);
    check({tag, "_data"},   32'(mem_px_data), 32'd0);
    check({tag, "_px_wr"},  32'(px_wr),       32'd0);
    check({tag, "_busy"},   32'(busy),        32'd1);
    check({tag, "_cursor"}, 32'(cursor),      32'd0);
  endtask

  task automatic wait_idle(input string tag);
    bit ok = 1'b0;
    for (int n = 0; n < 300; n++) begin
      @(negedge clk);
      #1;
      if (!busy && !px_wr && exp_q.size() == 0) begin
        ok = 1'b1;
        break;
      end
    end
    check({tag, "_idle"}, 32'(ok), 32'd1);
  endtask

  task automatic move(input bit right, input int old_c, input int new_c, input string tag);
    bit seen = 1'b0;
    push_wr(old_c, BG);
    push_wr(new_c, CUR);
    if (right) btn_right = 1'b1;
    else       btn_left  = 1'b1;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (px_wr) begin
        seen = 1'b1;
        break;
      end
    end
    check({tag, "_erase_seen"},   32'(seen),   32'd1);
    check({tag, "_erase_cursor"}, 32'(cursor), 32'(old_c));
    check({tag, "_erase_busy"},   32'(busy),   32'd1);
    @(negedge clk);
    check({tag, "_draw_wr"},     32'(px_wr),  32'd1);
    check({tag, "_draw_cursor"}, 32'(cursor), 32'(new_c));
    @(negedge clk);
    check({tag, "_done_wr"},   32'(px_wr), 32'd0);
    check({tag, "_done_busy"}, 32'(busy),  32'd0);
    btn_right = 1'b0;
    btn_left  = 1'b0;
    repeat (10) @(negedge clk);
    check({tag, "_queue"}, 32'(exp_q.size()), 32'd0);
  endtask

  always @(negedge clk) begin : monitor
    logic [11:0] e;
    if (mon_en && px_wr) begin
      ram[mem_px_addr] = mem_px_data;
      if (exp_q.size() == 0) begin
        check("spurious_wr", 32'(px_wr), 32'd0);
      end else begin
        e = exp_q.pop_front();
        check("wr_addr_data", 32'({mem_px_addr, mem_px_data}), 32'(e));
      end
    end
  end

  initial begin
    bit found;
    for (int i = 0; i < 64; i++) ram[i] = 'x;

    // Reset values, then the full clear followed by the initial cursor draw
    repeat (3) @(negedge clk);
    check_reset_vals("rst0");
    push_clear();
    mon_en = 1'b1;
    rst = 1'b1;
    wait_idle("clear");
    check("clear_cursor", 32'(cursor), 32'd0);
    for (int i = 0; i < 64; i++)
      check("ram_after_clear", 32'(ram[i]), 32'((i == 0) ? CUR : BG));

    // Moves and wrap-around
    move(1'b1, 0, 1, "right");
    move(1'b0, 1, 0, "left");
    move(1'b0, 0, 15, "wrap_left");
    move(1'b1, 15, 0, "wrap_right");
    check("ram_tile0", 32'(ram[0]),  32'(CUR));
    check("ram_tile15", 32'(ram[15]), 32'(BG));

    // Short bounces must never debounce
    for (int i = 0; i < 10; i++) begin
      btn_right = ~btn_right;
      repeat (2) @(negedge clk);
    end
    btn_right = 1'b0;
    repeat (10) @(negedge clk);
    check("bounce_cursor", 32'(cursor), 32'd0);

    // Simultaneous presses cancel
    btn_right = 1'b1;
    btn_left  = 1'b1;
    repeat (12) @(negedge clk);
    btn_right = 1'b0;
    btn_left  = 1'b0;
    repeat (12) @(negedge clk);
    check("both_cursor", 32'(cursor), 32'd0);
    check("both_busy",   32'(busy),   32'd0);
    check("both_queue",  32'(exp_q.size()), 32'd0);

    // Press landing during clear is dropped
    move(1'b1, 0, 1, "pre_reset");
    rst = 1'b0;
    repeat (2) @(negedge clk);
    check("rst2_cursor", 32'(cursor), 32'd0);
    push_clear();
    btn_right = 1'b1;
    rst = 1'b1;
    repeat (12) @(negedge clk);
    btn_right = 1'b0;
    wait_idle("busy_drop");
    check("busy_drop_cursor", 32'(cursor), 32'd0);

    // Reset in the middle of a clear restarts it from address 0
    rst = 1'b0;
    @(negedge clk);
    push_clear();
    rst = 1'b1;
    found = 1'b0;
    for (int n = 0; n < 100; n++) begin
      @(negedge clk);
      if (px_wr && mem_px_addr == 6'd30) begin
        found = 1'b1;
        break;
      end
    end
    check("midclear_reached30", 32'(found), 32'd1);
    #1;
    mon_en = 1'b0;
    exp_q.delete();
    rst = 1'b0;
    @(negedge clk);
    check_reset_vals("rst_mid");
    @(negedge clk);
    check_reset_vals("rst_mid2");
    push_clear();
    mon_en = 1'b1;
    rst = 1'b1;
    wait_idle("reclear");
    check("reclear_cursor", 32'(cursor), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
